// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin sharing of one ALU between two cores; one op in flight.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int OPCODE_LENGTH = 4,
    parameter int VECTOR_LENGTH = OPCODE_LENGTH + 2 * DATA_WIDTH,
    parameter int SHORT_LAT     = 2,
    parameter int LONG_LAT      = 6
) (
    input  logic                     clk,
    input  logic                     reset_in,
    input  logic                     c0_req_valid,
    input  logic [VECTOR_LENGTH-1:0] c0_req_vector,
    output logic                     c0_req_ready,
    output logic                     c0_rsp_valid,
    input  logic                     c0_rsp_ready,
    input  logic                     c1_req_valid,
    input  logic [VECTOR_LENGTH-1:0] c1_req_vector,
    output logic                     c1_req_ready,
    output logic                     c1_rsp_valid,
    input  logic                     c1_rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_result,
    output logic                     rsp_carry,
    output logic                     rsp_zero,
    output logic [VECTOR_LENGTH-1:0] alu_opcode_inputs,
    input  logic [DATA_WIDTH-1:0]    alu_final_output,
    input  logic                     alu_carry_output,
    input  logic                     alu_zero_flag,
    output logic                     busy,
    output logic                     owner
);

    localparam int MAX_LAT = (LONG_LAT > SHORT_LAT) ? LONG_LAT : SHORT_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [OPCODE_LENGTH-1:0] OP_MULT   = OPCODE_LENGTH'(3);
    localparam logic [OPCODE_LENGTH-1:0] OP_DIVIDE = OPCODE_LENGTH'(8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_last_grant;
    logic                     r_owner;
    logic                     w_grant_any;
    logic                     w_grant_core;
    logic                     w_grant_long;
    logic                     w_owner_rsp_ready;
    logic [VECTOR_LENGTH-1:0] w_grant_vector;
    logic [OPCODE_LENGTH-1:0] w_grant_opcode;

    // Under contention the core that did not win last time goes next.
    always_comb begin
        w_grant_any = (r_state == IDLE) && !reset_in && (c0_req_valid || c1_req_valid);
        if (c0_req_valid && c1_req_valid) begin
            w_grant_core = ~r_last_grant;
        end else begin
            w_grant_core = c1_req_valid;
        end
        w_grant_vector    = w_grant_core ? c1_req_vector : c0_req_vector;
        w_grant_opcode    = w_grant_vector[VECTOR_LENGTH-1 -: OPCODE_LENGTH];
        w_grant_long      = (w_grant_opcode == OP_MULT) || (w_grant_opcode == OP_DIVIDE);
        w_owner_rsp_ready = r_owner ? c1_rsp_ready : c0_rsp_ready;
    end

    assign c0_req_ready = w_grant_any && !w_grant_core;
    assign c1_req_ready = w_grant_any && w_grant_core;
    assign c0_rsp_valid = (r_state == DONE) && !r_owner;
    assign c1_rsp_valid = (r_state == DONE) && r_owner;
    assign busy         = (r_state != IDLE);
    assign owner        = r_owner;

    always_ff @(posedge clk) begin
        if (reset_in) begin
            r_state           <= IDLE;
            r_cnt             <= '0;
            r_last_grant      <= 1'b1;
            r_owner           <= 1'b0;
            alu_opcode_inputs <= '0;
            rsp_result        <= '0;
            rsp_carry         <= 1'b0;
            rsp_zero          <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_any) begin
                        r_owner           <= w_grant_core;
                        alu_opcode_inputs <= w_grant_vector;
                        r_cnt             <= w_grant_long ? CNT_W'(LONG_LAT) : CNT_W'(SHORT_LAT);
                        r_state           <= BUSY;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        rsp_result <= alu_final_output;
                        rsp_carry  <= alu_carry_output;
                        rsp_zero   <= alu_zero_flag;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    if (w_owner_rsp_ready) begin
                        r_last_grant <= r_owner;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Randomized scoreboard bench for alu_arbiter with an ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int SHORT_LAT = 2;
    localparam int LONG_LAT  = 6;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        c0_req_valid, c0_req_ready, c0_rsp_valid, c0_rsp_ready;
    logic        c1_req_valid, c1_req_ready, c1_rsp_valid, c1_rsp_ready;
    logic [19:0] c0_req_vector, c1_req_vector, alu_opcode_inputs;
    logic [7:0]  rsp_result, alu_final_output;
    logic        rsp_carry, rsp_zero, alu_carry_output, alu_zero_flag;
    logic        busy, owner;

    typedef struct {
        int          core;
        logic [19:0] vec;
        logic [9:0]  exp;   // {carry, zero, result}
        int          due;
    } op_t;

    op_t         q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          acc0 = 0, acc1 = 0;
    int          gap0 = 0, gap1 = 0;

    alu_arbiter dut (
        .clk               (clk),
        .reset_in          (reset_in),
        .c0_req_valid      (c0_req_valid),
        .c0_req_vector     (c0_req_vector),
        .c0_req_ready      (c0_req_ready),
        .c0_rsp_valid      (c0_rsp_valid),
        .c0_rsp_ready      (c0_rsp_ready),
        .c1_req_valid      (c1_req_valid),
        .c1_req_vector     (c1_req_vector),
        .c1_req_ready      (c1_req_ready),
        .c1_rsp_valid      (c1_rsp_valid),
        .c1_rsp_ready      (c1_rsp_ready),
        .rsp_result        (rsp_result),
        .rsp_carry         (rsp_carry),
        .rsp_zero          (rsp_zero),
        .alu_opcode_inputs (alu_opcode_inputs),
        .alu_final_output  (alu_final_output),
        .alu_carry_output  (alu_carry_output),
        .alu_zero_flag     (alu_zero_flag),
        .busy              (busy),
        .owner             (owner)
    );

    always #5 clk = ~clk;

    // ALU behaviour: 1 ADD, 2 SUB, 3 MULT, 8 DIVIDE, anything else XOR.
    function automatic logic [9:0] alu_f(input logic [19:0] v);
        logic [3:0]  op;
        logic [7:0]  a, b, r;
        logic [15:0] p;
        logic        c;
        op = v[19:16];
        a  = v[15:8];
        b  = v[7:0];
        c  = 1'b0;
        case (op)
            4'h1: {c, r} = {1'b0, a} + {1'b0, b};
            4'h2: {c, r} = {1'b0, a} - {1'b0, b};
            4'h3: begin p = a * b; r = p[7:0]; c = |p[15:8]; end
            4'h8: begin
                if (b == 8'd0) begin r = 8'hFF; c = 1'b1; end
                else r = a / b;
            end
            default: r = a ^ b;
        endcase
        return {c, (r == 8'd0), r};
    endfunction

    function automatic int lat_of(input logic [19:0] v);
        return (v[19:16] == 4'h3 || v[19:16] == 4'h8) ? LONG_LAT : SHORT_LAT;
    endfunction

    function automatic logic [19:0] rand_vec();
        logic [3:0] op;
        case ($urandom_range(0, 4))
            0:       op = 4'h1;
            1:       op = 4'h2;
            2:       op = 4'h3;
            3:       op = 4'h8;
            default: op = 4'($urandom_range(0, 15));
        endcase
        return {op, 8'($urandom), 8'($urandom_range(0, 255))};
    endfunction

    logic [9:0] alu_out;
    always_comb begin
        alu_out          = alu_f(alu_opcode_inputs);
        alu_carry_output = alu_out[9];
        alu_zero_flag    = alu_out[8];
        alu_final_output = alu_out[7:0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge.
    initial begin
        bit          rst_seen = 0;
        bit          last_grant = 1;
        logic [19:0] last_vec = '0;
        bit          was_busy, ev0, ev1, g0, g1, win;
        int          wait0 = 0, wait1 = 0;
        op_t         e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_seen) begin
                rst_seen = 0;
                chk("rst_busy", busy, 0);
                chk("rst_owner", owner, 0);
                chk("rst_c0_rsp_valid", c0_rsp_valid, 0);
                chk("rst_c1_rsp_valid", c1_rsp_valid, 0);
                chk("rst_result", rsp_result, 0);
                chk("rst_carry", rsp_carry, 0);
                chk("rst_zero", rsp_zero, 0);
                chk("rst_alu_vec", alu_opcode_inputs, 0);
            end
            if (reset_in) begin
                rst_seen   = 1;
                q.delete();
                last_grant = 1;
                last_vec   = '0;
                acc0       = 0;
                acc1       = 0;
                wait0      = 0;
                wait1      = 0;
                continue;
            end
            was_busy = (q.size() != 0);
            chk("busy", busy, was_busy);
            chk("alu_vec", alu_opcode_inputs, last_vec);
            ev0 = 0;
            ev1 = 0;
            if (was_busy) begin
                chk("owner", owner, q[0].core);
                ev0 = (q[0].core == 0) && (cyc >= q[0].due);
                ev1 = (q[0].core == 1) && (cyc >= q[0].due);
            end
            chk("c0_rsp_valid", c0_rsp_valid, ev0);
            chk("c1_rsp_valid", c1_rsp_valid, ev1);
            if (ev0 || ev1) begin
                chk("rsp_result", rsp_result, q[0].exp[7:0]);
                chk("rsp_carry", rsp_carry, q[0].exp[9]);
                chk("rsp_zero", rsp_zero, q[0].exp[8]);
                if ((ev0 && c0_rsp_ready) || (ev1 && c1_rsp_ready)) begin
                    last_grant = (q[0].core == 1);
                    void'(q.pop_front());
                end
            end
            g0 = 0;
            g1 = 0;
            if (!was_busy && (c0_req_valid || c1_req_valid)) begin
                win = (c0_req_valid && c1_req_valid) ? !last_grant : c1_req_valid;
                g0  = !win;
                g1  = win;
            end
            chk("c0_req_ready", c0_req_ready, g0);
            chk("c1_req_ready", c1_req_ready, g1);
            acc0 = g0;
            acc1 = g1;
            if (g0 || g1) begin
                e.core   = g1 ? 1 : 0;
                e.vec    = g1 ? c1_req_vector : c0_req_vector;
                e.exp    = alu_f(e.vec);
                e.due    = cyc + lat_of(e.vec) + 1;
                last_vec = e.vec;
                q.push_back(e);
            end
            wait0 = (c0_req_valid && !g0) ? wait0 + 1 : 0;
            wait1 = (c1_req_valid && !g1) ? wait1 + 1 : 0;
            if (c0_req_valid) chk("c0_starve", (wait0 < 60), 1);
            if (c1_req_valid) chk("c1_starve", (wait1 < 60), 1);
        end
    end

    task automatic step(input bit issuing, input bit rand_rdy, input bit rst);
        @(posedge clk);
        #1;
        reset_in = rst;
        if (acc0) begin
            c0_req_valid = 0;
            gap0 = $urandom_range(0, 3);
        end else if (issuing && c0_req_valid && $urandom_range(0, 39) == 0) begin
            c0_req_valid = 0;
        end else if (!c0_req_valid) begin
            if (gap0 > 0) gap0--;
            else if (issuing) begin c0_req_valid = 1; c0_req_vector = rand_vec(); end
        end
        if (acc1) begin
            c1_req_valid = 0;
            gap1 = $urandom_range(0, 3);
        end else if (issuing && c1_req_valid && $urandom_range(0, 39) == 0) begin
            c1_req_valid = 0;
        end else if (!c1_req_valid) begin
            if (gap1 > 0) gap1--;
            else if (issuing) begin c1_req_valid = 1; c1_req_vector = rand_vec(); end
        end
        c0_rsp_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
        c1_rsp_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
    endtask

    initial begin
        reset_in      = 1;
        c0_req_valid  = 0;
        c1_req_valid  = 0;
        c0_req_vector = '0;
        c1_req_vector = '0;
        c0_rsp_ready  = 0;
        c1_rsp_ready  = 0;
        repeat (3) @(posedge clk);
        #1 reset_in = 0;

        // Simultaneous first requests: ADD on core 0, MULT on core 1.
        @(posedge clk);
        #1;
        c0_req_valid  = 1;
        c0_req_vector = 20'h1FF01;
        c1_req_valid  = 1;
        c1_req_vector = 20'h30503;
        c0_rsp_ready  = 1;
        c1_rsp_ready  = 1;
        for (int i = 0; i < 100 && (c0_req_valid || c1_req_valid); i++) step(0, 0, 0);
        if (c0_req_valid || c1_req_valid) begin
            $display("FAIL directed_grant: requests still pending after 100 cycles");
            $fatal(1);
        end

        for (int i = 0; i < 1500; i++) step(1, 1, 0);

        // Reset while an operation is in flight.
        for (int i = 0; i < 200 && !busy; i++) step(1, 1, 0);
        if (!busy) begin
            $display("FAIL reset_setup: no operation started within 200 cycles");
            $fatal(1);
        end
        step(1, 1, 0);
        step(1, 1, 1);
        step(1, 1, 0);

        for (int i = 0; i < 1500; i++) step(1, 1, 0);

        for (int i = 0; i < 500 && (c0_req_valid || c1_req_valid || q.size() != 0); i++)
            step(0, 0, 0);
        if (c0_req_valid || c1_req_valid || q.size() != 0) begin
            $display("FAIL drain: work outstanding after 500 cycles");
            $fatal(1);
        end
        step(0, 0, 0);
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
